// File: rtl/dccm_if.sv
// LSU <-> DCCM word read/write bundle.
// The LSU drives requests; the DCCM returns responses.
interface dccm_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] lsu_dccm_raddr;
  logic            lsu_dccm_rvalid_in;
  logic [XLEN-1:0] lsu_dccm_rdata;
  logic            lsu_dccm_rvalid_out;
  logic [XLEN-1:0] lsu_dccm_waddr;
  logic            lsu_dccm_wen;
  logic [XLEN-1:0] lsu_dccm_wdata;

  modport master (
    output lsu_dccm_raddr,
    output lsu_dccm_rvalid_in,
    input  lsu_dccm_rdata,
    input  lsu_dccm_rvalid_out,
    output lsu_dccm_waddr,
    output lsu_dccm_wen,
    output lsu_dccm_wdata
  );

  modport slave (
    input  lsu_dccm_raddr,
    input  lsu_dccm_rvalid_in,
    output lsu_dccm_rdata,
    output lsu_dccm_rvalid_out,
    input  lsu_dccm_waddr,
    input  lsu_dccm_wen,
    input  lsu_dccm_wdata
  );
endinterface

// File: rtl/dccm.sv
// Data closely-coupled memory: word read/write responder for the LSU.
// Zero-fills itself after reset, then serves fixed-latency reads.
module dccm #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] DCCM_BASE    = '0,
  parameter int              DCCM_DEPTH   = 8192,
  parameter int              READ_LATENCY = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  dccm_if.slave lsu,
  output logic  dccm_init_done,
  output logic  dccm_err
);
  localparam int AW = $clog2(DCCM_DEPTH);
  localparam int L  = READ_LATENCY;
  localparam logic [XLEN:0] SPAN =
    {1'b0, XLEN'(DCCM_DEPTH)} << 2;

  typedef enum logic {
    S_INIT,
    S_READY
  } state_e;

  state_e          state;
  logic [AW-1:0]   clr_ptr;
  logic            ready;

  logic [XLEN-1:0] mem [DCCM_DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_idx;
  logic [XLEN-1:0] mem_d;

  logic [XLEN-1:0] roff;
  logic [XLEN-1:0] woff;
  logic            r_hit;
  logic            w_hit;
  logic [AW-1:0]   ridx;
  logic [AW-1:0]   widx;

  logic            wr_ok;
  logic            wr_err;
  logic            coll;
  logic            req_v;
  logic            req_e;
  logic [XLEN-1:0] req_d;

  logic [L-1:0]           pv_q;
  logic [L-1:0]           pe_q;
  logic [L-1:0][XLEN-1:0] pd_q;
  logic [L:0]             pv_all;
  logic [L:0]             pe_all;
  logic [L:0][XLEN-1:0]   pd_all;
  logic                   unused_tail;

  assign ready = (state == S_READY);

  assign roff  = lsu.lsu_dccm_raddr - DCCM_BASE;
  assign woff  = lsu.lsu_dccm_waddr - DCCM_BASE;
  assign r_hit = (lsu.lsu_dccm_raddr >= DCCM_BASE) &&
                 ({1'b0, roff} < SPAN);
  assign w_hit = (lsu.lsu_dccm_waddr >= DCCM_BASE) &&
                 ({1'b0, woff} < SPAN);
  assign ridx  = roff[AW+1:2];
  assign widx  = woff[AW+1:2];

  assign wr_ok  = ready && lsu.lsu_dccm_wen && w_hit;
  assign wr_err = lsu.lsu_dccm_wen && (!ready || !w_hit);
  assign coll   = wr_ok && (widx == ridx);
  assign req_v  = lsu.lsu_dccm_rvalid_in;
  assign req_e  = req_v && ready && !r_hit;

  // Read data is fixed at request time; same-cycle write wins.
  always_comb begin
    req_d = '0;
    if (req_v && ready && r_hit) begin
      req_d = coll ? lsu.lsu_dccm_wdata : mem[ridx];
    end
  end

  assign mem_we  = !ready || wr_ok;
  assign mem_idx = ready ? widx : clr_ptr;
  assign mem_d   = ready ? lsu.lsu_dccm_wdata : '0;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_INIT;
      clr_ptr        <= '0;
      dccm_init_done <= 1'b0;
    end else begin
      unique case (state)
        S_INIT: begin
          clr_ptr <= clr_ptr + AW'(1);
          if (clr_ptr == AW'(DCCM_DEPTH - 1)) begin
            state          <= S_READY;
            dccm_init_done <= 1'b1;
          end
        end
        S_READY: begin
          dccm_init_done <= 1'b1;
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

  assign pv_all = {pv_q, req_v};
  assign pe_all = {pe_q, req_e};
  assign pd_all = {pd_q, req_d};

  // Error is registered one stage early so it lines up with rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q     <= '0;
      pe_q     <= '0;
      pd_q     <= '0;
      dccm_err <= 1'b0;
    end else begin
      pv_q     <= pv_all[L-1:0];
      pe_q     <= pe_all[L-1:0];
      pd_q     <= pd_all[L-1:0];
      dccm_err <= wr_err | pe_all[L-1];
    end
  end

  assign lsu.lsu_dccm_rvalid_out = pv_q[L-1];
  assign lsu.lsu_dccm_rdata      = pd_q[L-1];

  assign unused_tail = ^{pv_all[L], pe_all[L], pd_all[L]};
endmodule

// File: tb/tb_dccm.sv
// Bench for dccm: three latencies driven in lockstep against
// a cycle-keyed reference model, plus table and corner sequences.
module tb_dccm;
  localparam int DEPTH = 8192;
  localparam longint unsigned BASE = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] raddr, waddr, wdata;
  logic        rv, wen;

  dccm_if b1 ();
  dccm_if b2 ();
  dccm_if b3 ();

  logic [31:0] rd  [1:3];
  logic        vo  [1:3];
  logic        idn [1:3];
  logic        er  [1:3];

  assign b1.lsu_dccm_raddr     = raddr;
  assign b1.lsu_dccm_rvalid_in = rv;
  assign b1.lsu_dccm_waddr     = waddr;
  assign b1.lsu_dccm_wen       = wen;
  assign b1.lsu_dccm_wdata     = wdata;
  assign b2.lsu_dccm_raddr     = raddr;
  assign b2.lsu_dccm_rvalid_in = rv;
  assign b2.lsu_dccm_waddr     = waddr;
  assign b2.lsu_dccm_wen       = wen;
  assign b2.lsu_dccm_wdata     = wdata;
  assign b3.lsu_dccm_raddr     = raddr;
  assign b3.lsu_dccm_rvalid_in = rv;
  assign b3.lsu_dccm_waddr     = waddr;
  assign b3.lsu_dccm_wen       = wen;
  assign b3.lsu_dccm_wdata     = wdata;

  assign rd[1] = b1.lsu_dccm_rdata;
  assign rd[2] = b2.lsu_dccm_rdata;
  assign rd[3] = b3.lsu_dccm_rdata;
  assign vo[1] = b1.lsu_dccm_rvalid_out;
  assign vo[2] = b2.lsu_dccm_rvalid_out;
  assign vo[3] = b3.lsu_dccm_rvalid_out;

  dccm #(.READ_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .lsu(b1),
    .dccm_init_done(idn[1]), .dccm_err(er[1]));
  dccm #(.READ_LATENCY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .lsu(b2),
    .dccm_init_done(idn[2]), .dccm_err(er[2]));
  dccm #(.READ_LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n), .lsu(b3),
    .dccm_init_done(idn[3]), .dccm_err(er[3]));

  int nerr = 0;
  int nchk = 0;
  int cyc = 0;
  int psr = 0;

  // Model: logical memory plus expected outputs keyed by cycle.
  logic [31:0] mm [DEPTH];
  bit          ev [int];
  logic [31:0] ed [int];
  bit          ee [int];
  bit          ew [int];

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic bit in_rng(logic [31:0] a);
    longint unsigned x = a;
    return (x >= BASE) && (x < BASE + 4 * DEPTH);
  endfunction

  function automatic int word(logic [31:0] a);
    longint unsigned x = a;
    return int'((x - BASE) / 4);
  endfunction

  function automatic void cmp_cycle();
    for (int l = 1; l <= 3; l++) begin
      int k = cyc * 4 + l;
      bit xv = ev.exists(k) ? ev[k] : 1'b0;
      logic [31:0] xd = ed.exists(k) ? ed[k] : 32'h0;
      bit xe = ee.exists(k) ? ee[k] : 1'b0;
      bit xw = ew.exists(cyc) ? ew[cyc] : 1'b0;
      chk($sformatf("rvalid L%0d", l), vo[l], xv);
      chk($sformatf("rdata L%0d", l), rd[l], xd);
      chk($sformatf("err L%0d", l), er[l], xe | xw);
      chk($sformatf("init_done L%0d", l), idn[l],
          psr >= DEPTH);
    end
  endfunction

  task automatic step();
    int p;
    bit rdy;
    logic [31:0] v;
    p = cyc + 1;
    rdy = (psr >= DEPTH);
    if (rv) begin
      if (!rdy || !in_rng(raddr)) v = 32'h0;
      else if (rdy && wen && in_rng(waddr) &&
               word(waddr) == word(raddr)) v = wdata;
      else v = mm[word(raddr)];
      for (int l = 1; l <= 3; l++) begin
        ev[(p + l - 1) * 4 + l] = 1'b1;
        ed[(p + l - 1) * 4 + l] = v;
        ee[(p + l - 1) * 4 + l] = rdy && !in_rng(raddr);
      end
    end
    if (wen) begin
      if (!rdy || !in_rng(waddr)) ew[p] = 1'b1;
      else mm[word(waddr)] = wdata;
    end
    @(posedge clk);
    cyc = p;
    psr++;
    #1;
    cmp_cycle();
  endtask

  task automatic idle();
    rv = 1'b0;
    wen = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int l = 1; l <= 3; l++) begin
      chk($sformatf("rst rvalid L%0d", l), vo[l], 0);
      chk($sformatf("rst rdata L%0d", l), rd[l], 0);
      chk($sformatf("rst err L%0d", l), er[l], 0);
      chk($sformatf("rst init L%0d", l), idn[l], 0);
    end
    ev.delete();
    ed.delete();
    ee.delete();
    ew.delete();
    for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
    psr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst hold rvalid L2", vo[2], 0);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_addr();
    int s = $urandom_range(0, 9);
    logic [31:0] a;
    if (s < 5) a = 32'($urandom_range(0, 15)) << 2;
    else if (s < 8)
      a = 32'(DEPTH - 1 - $urandom_range(0, 7)) << 2;
    else if (s == 8)
      a = 32'h8000 + (32'($urandom_range(0, 63)) << 2);
    else a = $urandom;
    return a | 32'($urandom_range(0, 3));
  endfunction

  typedef struct {
    logic [31:0] raddr;
    logic        rv;
    logic [31:0] waddr;
    logic        wen;
    logic [31:0] wdata;
    logic        xv;
    logic [31:0] xd;
    logic        xe;
  } vec_t;

  vec_t tbl [14];
  int n;

  initial begin
    tbl[0]  = '{32'h0FF0, 1, 32'h0, 0, 32'h0,
                1, 32'h0, 0};
    tbl[1]  = '{32'h0, 0, 32'h1FF0, 1, 32'hDEADBEEF,
                0, 32'h0, 0};
    tbl[2]  = '{32'h1FF3, 1, 32'h0, 0, 32'h0,
                1, 32'hDEADBEEF, 0};
    tbl[3]  = '{32'h0, 0, 32'h2FF0, 1, 32'hA5A5A5A5,
                0, 32'h0, 0};
    tbl[4]  = '{32'h2FF0, 1, 32'h0, 0, 32'h0,
                1, 32'hA5A5A5A5, 0};
    tbl[5]  = '{32'h2FF0, 1, 32'h2FF0, 1, 32'h12345678,
                1, 32'h12345678, 0};
    tbl[6]  = '{32'h2FF1, 1, 32'h0, 0, 32'h0,
                1, 32'h12345678, 0};
    tbl[7]  = '{32'h8000, 1, 32'h8004, 1, 32'h55,
                1, 32'h0, 1};
    tbl[8]  = '{32'h0004, 1, 32'h0, 0, 32'h0,
                1, 32'h0, 0};
    tbl[9]  = '{32'h0, 0, 32'h7FFC, 1, 32'hCAFEF00D,
                0, 32'h0, 0};
    tbl[10] = '{32'h7FFE, 1, 32'h0, 0, 32'h0,
                1, 32'hCAFEF00D, 0};
    tbl[11] = '{32'h0, 0, 32'hFFFFFFFC, 1, 32'h1,
                0, 32'h0, 1};
    tbl[12] = '{32'h9000, 0, 32'h9000, 0, 32'h2,
                0, 32'h0, 0};
    tbl[13] = '{32'h0, 0, 32'h0, 0, 32'h0,
                0, 32'h0, 0};

    raddr = '0;
    waddr = '0;
    wdata = '0;
    idle();
    #2;
    do_reset();

    n = 0;
    while (idn[1] !== 1'b1 && n < DEPTH + 8) begin
      raddr = 32'h10;
      rv = (n == 100);
      step();
      n++;
    end
    idle();
    chk("init cycles", n, DEPTH);

    foreach (tbl[i]) begin
      raddr = tbl[i].raddr;
      rv    = tbl[i].rv;
      waddr = tbl[i].waddr;
      wen   = tbl[i].wen;
      wdata = tbl[i].wdata;
      step();
      chk($sformatf("tbl%0d rvalid", i), vo[1], tbl[i].xv);
      chk($sformatf("tbl%0d rdata", i), rd[1], tbl[i].xd);
      chk($sformatf("tbl%0d err", i), er[1], tbl[i].xe);
    end
    idle();

    for (int i = 0; i < 3; i++) begin
      waddr = 32'h4000 + 32'(i * 4);
      wdata = 32'(i + 1);
      wen = 1'b1;
      step();
    end
    idle();
    raddr = 32'h4000; rv = 1'b1; step();
    raddr = 32'h4004; step();
    raddr = 32'h4008;
    waddr = 32'h4004; wdata = 32'd9; wen = 1'b1;
    step();
    idle();
    chk("pipe r0 v", vo[3], 1);
    chk("pipe r0 d", rd[3], 1);
    step();
    chk("pipe r1 v", vo[3], 1);
    chk("pipe r1 d", rd[3], 2);
    step();
    chk("pipe r2 v", vo[3], 1);
    chk("pipe r2 d", rd[3], 3);
    step();
    chk("pipe end v", vo[3], 0);
    raddr = 32'h4004; rv = 1'b1; step(); idle();
    chk("pipe wr landed", rd[1], 9);

    raddr = 32'h1FF0; rv = 1'b1; step(); idle();
    do_reset();
    n = 0;
    while (idn[1] !== 1'b1 && n < DEPTH + 8) begin
      waddr = 32'h100;
      wdata = 32'h77;
      wen = (n == 5);
      step();
      if (n == 5) chk("init write err", er[1], 1);
      n++;
    end
    idle();
    chk("reinit cycles", n, DEPTH);
    raddr = 32'h1FF0; rv = 1'b1; step(); idle();
    chk("post-reset v", vo[1], 1);
    chk("post-reset d", rd[1], 0);

    for (int i = 0; i < 3000; i++) begin
      raddr = rnd_addr();
      waddr = rnd_addr();
      wdata = $urandom;
      rv    = 1'($urandom_range(0, 1));
      wen   = ($urandom_range(0, 2) == 0);
      step();
    end
    idle();
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/dccm.md
Name: dccm

Overview:
Data closely-coupled memory (DCCM): the responder on the LSU DCCM interface.
- It accepts word reads and word writes from the LSU.
- It returns read data after a fixed latency, with a valid strobe.
- It flags out-of-range accesses.
- After reset it zero-fills itself before normal operation begins.
- It sits beside the LSU in the core and replaces the bench memory stub.

Parameters:
- DCCM_BASE, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- DCCM_DEPTH, 8192, number of XLEN-bit words (32 KiB); must be a power of 2.
- READ_LATENCY, 1, cycles from read request to response; legal range 1..4.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- lsu_dccm_raddr  in  XLEN  read byte address; bits [1:0] ignored
- lsu_dccm_rvalid_in  in  1  read request, one request per asserted cycle
- lsu_dccm_rdata  out  XLEN  read data
- lsu_dccm_rvalid_out  out  1  read response valid
- lsu_dccm_waddr  in  XLEN  write byte address; bits [1:0] ignored
- lsu_dccm_wen  in  1  full-word write enable
- lsu_dccm_wdata  in  XLEN  write data
- dccm_init_done  out  1  high once the zero-fill is complete
- dccm_err  out  1  one-cycle error pulse

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs go to 0.
  - The read pipeline is cleared and in-flight reads are discarded (no rvalid_out).
  - The FSM enters INIT and the clear pointer is set to 0.
  - Array contents are not reset directly; the INIT state clears them.
- FSM states:
  - INIT: writes 0 to word[clr_ptr] each cycle and increments clr_ptr. When clr_ptr = DCCM_DEPTH-1 has been written, the next state is READY. INIT lasts exactly DCCM_DEPTH cycles after rst_n deasserts.
  - READY: dccm_init_done=1. The block stays in READY until reset.
- Address decode:
  - An address is in range iff DCCM_BASE <= addr < DCCM_BASE + 4*DCCM_DEPTH (unsigned compare).
  - Word index = (addr - DCCM_BASE)[log2(DCCM_DEPTH)+1:2].
- Reads:
  - A request sampled at posedge N gives lsu_dccm_rvalid_out=1 and lsu_dccm_rdata valid during cycle N+READ_LATENCY.
  - Both signals are registered. Back-to-back requests every cycle are supported at full throughput, with responses returned in order.
  - The read value is captured at request time. A write accepted after the request does not alter that response.
  - rdata = 0 and rvalid_out = 0 whenever no response is due.
- Writes:
  - In READY, an in-range write with wen=1 updates the word at the posedge. Writes are full-word only; sub-word stores are merged by the LSU.
- Same-cycle read and write to the same index (READY): write-first. The response carries lsu_dccm_wdata.
- Reads during INIT:
  - The response is still produced at normal latency, with rdata = 0 (memory is logically zero).
  - No error is flagged.
- Writes during INIT: the write is dropped and dccm_err pulses at N+1.
- Out-of-range read: rvalid_out is still asserted at N+READ_LATENCY, with rdata = 0 and dccm_err=1 in that same cycle.
- Out-of-range write: the write is dropped and dccm_err=1 at N+1.
- Error pulses that coincide in one cycle (read error and write error) merge into a single-cycle pulse. dccm_err is never held high by a single event.
- rvalid_in=0 makes raddr a don't-care; wen=0 makes waddr and wdata don't-cares. Neither can produce an error in that case.
- Reset mid-operation: outputs drop at the asynchronous reset edge, and no response for earlier requests ever appears. INIT restarts from word 0.

Test Plan:
- Init and zero read:
  - Stimulus: release rst_n; count cycles until dccm_init_done=1. Then read 0x0000_0FF0 at READ_LATENCY=1.
  - Required response: init_done=1 exactly DCCM_DEPTH cycles after release; rvalid_out=1 one cycle after the request with rdata=0; dccm_err stays 0.
- Write then read:
  - Stimulus: write 0xDEAD_BEEF to 0x0000_1FF0, then read 0x0000_1FF3 on the next cycle.
  - Required response: rdata=0xDEAD_BEEF, since bits [1:0] are ignored.
- Collision:
  - Stimulus: write 0x1234_5678 and read the same address 0x0000_2FF0 in the same cycle, where the word previously held 0xA5A5_A5A5.
  - Required response: the response is 0x1234_5678.
- Pipelined reads, READ_LATENCY=3:
  - Stimulus: preload 0x4000=1, 0x4004=2, 0x4008=3. Issue reads to 0x4000, 0x4004, 0x4008 on consecutive cycles, and write 9 to 0x4004 in the cycle after its read.
  - Required response: responses 1, 2, 3 appear on three consecutive cycles starting 3 cycles after the first request.
- Out of range:
  - Stimulus: read 0x0000_8000 and write 0x0000_8004 in the same cycle.
  - Required response: the write is dropped; a single err pulse at N+1, coincident with rvalid_out=1 and rdata=0.
- Reset mid-operation:
  - Stimulus: issue a read at READ_LATENCY=2 and assert rst_n one cycle later.
  - Required response: rvalid_out never asserts for that read; init_done=0 until the INIT state repeats.
  - Then: a write made during INIT raises err; a read of previously written 0x1FF0 after INIT returns 0.
